averaging_stimulus: RTL and testbench
=====================================

Name: averaging_stimulus

Overview:
Sequencer that drives the control strobes of a sample-averaging adder. After each release of reset, it emits one fixed sequence: clear the accumulator, add exactly sample_count samples, then show the result. After that it goes idle until the next reset. In the system, reset is driven by the slow PI-control clock, and the sequencer runs on the fast adder clock. Each slow-clock phase therefore triggers one averaging window.

Parameters:
sample_count, 9, number of consecutive cycles add is asserted per window; legal range 1..65535

Ports:
clock  input  1  adder clock; all state changes on rising edge
reset  input  1  asynchronous, active-low reset; low = hold/abort, high = run
clear  output 1  one-cycle strobe: zero the accumulator
add    output 1  asserted for sample_count consecutive cycles: accumulate one sample per cycle
show   output 1  one-cycle strobe: publish the accumulated result

Behaviour:
- One clock; reset is asynchronous and active-low.
- Outputs are registered: driven directly from state/counter flops, no combinational path from reset deassertion to outputs.
- While reset=0: state=START, counter=0, clear=add=show=0. Asserting reset forces this immediately, independent of clock.
- FSM states: START, CLEAR, ADD, SHOW, DONE.
- Edges are counted from the first rising clock edge with reset=1.
- START -> CLEAR at edge 1: clear=1 for exactly one cycle.
- CLEAR -> ADD at edge 2: add=1; counter loads sample_count-1.
- ADD: counter decrements each edge.
  - When counter==0, next edge -> SHOW.
  - add is high for exactly sample_count cycles, edges 2..sample_count+1.
- SHOW at edge sample_count+2: show=1 for exactly one cycle.
- SHOW -> DONE at the next edge; all outputs 0.
- DONE is terminal: no further strobes until reset goes low and then high again.
- Outputs are mutually exclusive; at most one is high in any cycle.
- Total sequence: sample_count+2 active cycles.
- sample_count=1: clear, add, show on three consecutive cycles.
- Counter width: $clog2(sample_count+1), minimum 1 bit. No wrap-around is possible because the counter never decrements below 0.
- Reset mid-sequence (in any state): outputs drop to 0 asynchronously. The next release restarts at START, producing a full new sequence; there is no partial resume.
- Reset shorter than one clock period still aborts and restarts.
- Reset released for fewer than sample_count+2 cycles yields a truncated sequence; show never occurs in that window.
- Elaboration check: sample_count < 1 is a fatal error.

Decomposition:
- Shared package averaging_pkg holds:
  - the state enum typedef: START, CLEAR, ADD, SHOW, DONE;
  - a counter-width helper function, reused by the averaging adder.
- No sub-module: the FSM plus down-counter live in one module.

Test Plan:
- sample_count=9, clock period 2 ns, reset high from t=0 -> clear at edge 1; add high edges 2..10 (9 cycles, 18 ns); show at edge 11; then all 0 until reset falls.
- Hold reset low 30 ns, release -> outputs stay 0 during low; identical 11-cycle sequence restarts from edge 1 after release.
- Drop reset low during add (after 4 add cycles) -> add falls immediately (asynchronous); on release, clear then a fresh 9 add cycles, not 5.
- sample_count=1 -> clear, add, show on edges 1, 2, 3, each exactly one cycle; DONE afterward.
- Every cycle, all configurations -> at most one of clear/add/show high; show never follows fewer than sample_count add cycles since the last clear.
- Reset high only 6 cycles with sample_count=9 -> clear plus 5 add cycles, no show; next window complete.

Source files
------------

// File: rtl/averaging_pkg.sv
// Shared types and helpers for the sample-averaging datapath.
package averaging_pkg;

    // Sequencer states for one averaging window.
    typedef enum logic [2:0] {
        START = 3'd0,
        CLEAR = 3'd1,
        ADD   = 3'd2,
        SHOW  = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Bits needed to hold values 0..n; never narrower than one bit.
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/averaging_stimulus.sv
// One-shot strobe sequencer for an averaging adder: after every reset
// release it emits clear, then sample_count add cycles, then show, and
// parks in DONE until the next reset.
module averaging_stimulus
    import averaging_pkg::*;
#(
    parameter int sample_count = 9
) (
    input  logic clock,
    input  logic reset,
    output logic clear,
    output logic add,
    output logic show
);

    localparam int CNT_W = cnt_width(sample_count);
    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t CNT_LOAD = cnt_t'(sample_count - 1);
    localparam cnt_t CNT_ONE  = cnt_t'(1);

    generate
        if (sample_count < 1) begin : g_bad_count
            $fatal(1, "averaging_stimulus: sample_count must be >= 1");
        end
    endgenerate

    state_t state_q, state_d;
    cnt_t   cnt_q,   cnt_d;
    logic   clear_q, clear_d;
    logic   add_q,   add_d;
    logic   show_q,  show_d;

    // Next-state, counter and output decode. Outputs are decoded from the
    // next state so the strobe flops line up with the state they describe.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            START: state_d = CLEAR;
            CLEAR: begin
                state_d = ADD;
                cnt_d   = CNT_LOAD;
            end
            ADD: begin
                if (cnt_q == '0) begin
                    state_d = SHOW;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            SHOW:    state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = START;
        endcase
        clear_d = (state_d == CLEAR);
        add_d   = (state_d == ADD);
        show_d  = (state_d == SHOW);
    end

    // State, counter and strobe registers; reset aborts instantly.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= START;
            cnt_q   <= '0;
            clear_q <= 1'b0;
            add_q   <= 1'b0;
            show_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clear_q <= clear_d;
            add_q   <= add_d;
            show_q  <= show_d;
        end
    end

    assign clear = clear_q;
    assign add   = add_q;
    assign show  = show_q;

endmodule

// File: tb/tb_averaging_stimulus.sv
// Randomised scoreboard bench for averaging_stimulus, two configurations
// (sample_count 9 and 1) sharing one clock and one reset.
`timescale 1ns/1ps
module tb_averaging_stimulus;

    logic clock = 1'b1;
    logic reset = 1'b0;
    logic clear9, add9, show9;
    logic clear1, add1, show1;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [2:0] e9;
        logic [2:0] e1;
    } exp_t;
    exp_t sb[$];

    int k = 0;          // rising edges seen with reset high since last low
    int adds9 = 0;
    int adds1 = 0;

    always #1 clock = ~clock;

    averaging_stimulus #(.sample_count(9)) dut9 (
        .clock(clock), .reset(reset), .clear(clear9), .add(add9), .show(show9)
    );
    averaging_stimulus #(.sample_count(1)) dut1 (
        .clock(clock), .reset(reset), .clear(clear1), .add(add1), .show(show1)
    );

    task automatic chk(input string name, input logic [2:0] act, input logic [2:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s at %0t: got {clear,add,show}=%b required %b", name, $time, act, req);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s at %0t: got %0d required %0d", name, $time, act, req);
        end
    endtask

    // Reference: the window is a pure function of how many edges have
    // passed with reset high.
    function automatic logic [2:0] expv(input int kk, input int n);
        logic c, a, s;
        c = (kk == 1);
        a = (kk >= 2) && (kk <= n + 1);
        s = (kk == n + 2);
        return {c, a, s};
    endfunction

    // Drive one cycle (at the falling edge); optional short low glitch.
    task automatic step(input logic rv, input bit glitch);
        @(negedge clock);
        if (glitch || (reset && !rv)) begin
            reset = 1'b0;
            #0.25;
            chk("async_drop_n9", {clear9, add9, show9}, 3'b000);
            chk("async_drop_n1", {clear1, add1, show1}, 3'b000);
        end
        reset = rv;
        if (!rv || glitch) k = 0;
        if (rv) k++;
        sb.push_back('{e9: expv(k, 9), e1: expv(k, 1)});
    endtask

    task automatic run(input logic rv, input int n);
        for (int i = 0; i < n; i++) step(rv, 1'b0);
    endtask

    // Monitor: pop one expectation per edge and check invariants.
    always @(posedge clock) begin
        exp_t e;
        #0.5;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("seq_n9", {clear9, add9, show9}, e.e9);
            chk("seq_n1", {clear1, add1, show1}, e.e1);
        end
        chk_int("onehot_n9", (32'(clear9) + 32'(add9) + 32'(show9)) <= 1, 1);
        chk_int("onehot_n1", (32'(clear1) + 32'(add1) + 32'(show1)) <= 1, 1);
        if (clear9) adds9 = 0;
        if (add9) adds9++;
        if (show9) chk_int("adds_before_show_n9", adds9, 9);
        if (clear1) adds1 = 0;
        if (add1) adds1++;
        if (show1) chk_int("adds_before_show_n1", adds1, 1);
    end

    initial begin
        // reset state
        run(1'b0, 3);
        // full window, then idle in DONE
        run(1'b1, 15);
        // long reset, then identical window
        run(1'b0, 15);
        run(1'b1, 15);
        // abort after clear + 4 adds, fresh full window afterwards
        run(1'b0, 2);
        run(1'b1, 5);
        run(1'b0, 2);
        run(1'b1, 14);
        // sub-cycle reset glitch during add restarts the window
        run(1'b1, 0);
        run(1'b0, 1);
        run(1'b1, 5);
        step(1'b1, 1'b1);
        run(1'b1, 14);
        // truncated window: 6 high cycles, no show
        run(1'b0, 2);
        run(1'b1, 6);
        run(1'b0, 2);
        run(1'b1, 14);
        // random reset activity
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 14) != 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0);
        end
        run(1'b0, 2);
        @(posedge clock);
        #0.75;
        chk_int("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
